spmv_vec_rd_streamer: RTL
=========================

# spmv_vec_rd_streamer

Read-side initiator for the team's single-clock simple dual-port RAM, which has a registered read port with one cycle of read latency. It accepts a burst command (base address, length), issues one read per cycle on the RAM read port, and returns the words as a valid/ready stream with a last flag. A 2-entry output buffer absorbs the RAM latency under backpressure. The block sits between the SpMV vector/row buffers and the multiply-accumulate datapath.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.
- LEN_WIDTH, ADDR_WIDTH+1, burst length width; lengths up to 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge.
- cmd_base  in  ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  number of words to read.
- mem_re  out  1  RAM read enable.
- mem_raddr  out  ADDR_WIDTH  RAM read address.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_re.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  word.
- out_last  out  1  final beat of a burst.
- busy  out  1  high while not IDLE.

## Operation
- FSM with two states. IDLE: cmd_ready=1. READ: cmd_ready=0. busy = (state==READ).
- Command handshake in IDLE: if cmd_len==0, stay IDLE with no reads and no beats. Otherwise latch addr=cmd_base and rem=cmd_len, then go to READ.
- Issue rule in READ: mem_re = (rem!=0) && (occ + infl - pop < 2).
  - occ is the buffer occupancy (0..2).
  - infl is high in the cycle after a read is issued.
  - pop = out_valid && out_ready.
- On each issue: mem_raddr=addr, addr<=addr+1 (wraps modulo 2^ADDR_WIDTH), rem<=rem-1. The issued read is tagged last when rem==1, and the tag travels with infl.
- Capture: in any cycle with infl=1, mem_rdata and its last tag are written into the buffer unconditionally. The issue rule guarantees there is space.
- Buffer: 2-entry FIFO. out_data/out_last show the head entry. out_valid = (occ!=0). A push and a pop in the same cycle leave occ unchanged.
- Return to IDLE on the edge that pops the entry tagged last.
- Coherency with writes on the RAM write port is the writer's responsibility. Returned data is whatever the RAM delivers, including its bypass data.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, so cmd_ready=1 and busy=0.
  - mem_re=0, mem_raddr=0.
  - out_valid=0, out_last=0, out_data=0.
  - occ=0, infl=0, rem=0, addr=0.
- Reset asserted mid-burst: in-flight and buffered data are discarded, and all outputs go to their reset values immediately.
- Latency, counting from the command-accept edge E0:
  - The first mem_re is high in the cycle after E0.
  - RAM data arrives in the next cycle and is captured at edge E2.
  - out_valid is first high in the cycle after E2, i.e. the 3rd cycle after E0.
- Throughput: one beat per cycle while out_ready=1. Steady state is occ=1, infl=1, one issue per cycle.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable. occ + infl never exceeds 2, so no word is lost or duplicated.
- After the final pop, cmd_ready=1 in the next cycle. There are no idle beats between bursts beyond the 3-cycle latency.
- mem_raddr is don't-care when mem_re=0, but it must hold its last value (no toggling).

## Test plan
- base=0x10, len=4, out_ready=1, RAM preloaded with mem[a]=a -> beats 0x10,0x11,0x12,0x13 on consecutive cycles; out_last only on 0x13; first out_valid 3 cycles after the handshake; cmd_ready=1 the cycle after the last pop.
- len=0 -> no mem_re, no out_valid; cmd_ready remains 1 and busy remains 0.
- ADDR_WIDTH=4, base=14, len=4 -> mem_raddr sequence 14,15,0,1; data matches; last on the word from address 1.
- len=8 with out_ready low for 5 cycles mid-burst, then toggled every cycle -> out_data stable while stalled, occ+infl≤2 asserted every cycle, all 8 words delivered in order exactly once.
- len=1, base=0x3FF -> single beat with out_last=1; FSM back to IDLE after the pop.
- rst_n pulsed low during beat 3 of a len=6 burst -> outputs at reset values immediately; a new len=2 burst afterwards returns exactly 2 correct beats with no stale data.

Source files
------------

// File: rtl/spmv_vec_rd_streamer.sv
// SpMV vector read streamer: bursts reads from a 1-cycle-latency RAM
// and returns the words as a valid/ready stream with a last flag.
module spmv_vec_rd_streamer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  rem;
  logic [1:0]            occ;
  logic                  infl;
  logic                  infl_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic [2:0]            level;

  assign accept = (state == IDLE) && cmd_valid
               && (cmd_len != '0);
  assign pop    = out_valid && out_ready;
  assign push   = infl;
  assign level  = {1'b0, occ} + {2'b0, infl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = READ;
      READ: if (pop && fifo_last[rd_ptr]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue only when the buffer can take the word after this cycle's pop
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    mem_re    = 1'b0;
    unique case (state)
      IDLE: cmd_ready = 1'b1;
      READ: begin
        busy   = 1'b1;
        mem_re = (rem != '0)
              && (level < (3'd2 + {2'b0, pop}));
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign mem_raddr = addr;
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid && fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      rem       <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      infl      <= mem_re;
      infl_last <= mem_re && (rem == LEN_WIDTH'(1));
      if (accept) begin
        addr <= cmd_base;
        rem  <= cmd_len;
      end else if (mem_re) begin
        addr <= addr + ADDR_WIDTH'(1);
        rem  <= rem - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_last[wr_ptr] <= infl_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
